mem_port_responder: RTL and testbench

- Responder end of the CPU's split instruction/data memory interface.
- Accepts the CPU's inst fetch and data load/store requests and serialises them onto one word-wide downstream memory port.
- Returns completion to the CPU under the joint-response rule: the pipeline advances only when inst_resp is high, and also data_resp when a data access is pending. Both responses are therefore issued in the same cycle.
- Sits between the datapath and the memory/cache model at the top level of mp3.

---
 rtl/mem_port_responder_pkg.sv | 27 ++
 rtl/mem_port_responder.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_responder_pkg.sv
// Shared types for the split I/D memory port responder.
// State encoding for the serialising FSM and the captured data-operation kind.
// Word-alignment helper used when driving the downstream address.
package mem_resp_types;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA_ACC = 2'd1,
    INST_ACC = 2'd2,
    RESP     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } data_op_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  FULL_MBE  = 4'b1111;

  // Downstream memory is word-wide, so the byte offset is always dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/mem_port_responder.sv
// Responder for the CPU's split instruction/data memory interface.
// Latency: 1 (IDLE) + N per access + 1 (RESP); 2N+2 for fetch plus data access.
// Backpressure: downstream strobes are held until mem_resp; CPU requests wait at level until the joint response.
module mem_port_responder
  import mem_resp_types::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_resp,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mbe,
  output logic [31:0] data_rdata,
  output logic        data_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mbe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  state_e      state_q, state_d;
  logic        inst_pend_q;
  logic        inst_done_q;
  logic        data_done_q;
  data_op_e    data_op_q;
  logic [31:0] inst_addr_q;
  logic [31:0] data_addr_q;
  logic [31:0] data_wdata_q;
  logic [3:0]  data_mbe_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;

  logic        req_any;
  logic        data_req;

  assign data_req   = data_read | data_write;
  assign req_any    = inst_read | data_req;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // State register; reset abandons any in-flight downstream access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture CPU request in IDLE, then track which accesses have completed and latch read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_pend_q  <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      data_op_q    <= NONE;
      inst_addr_q  <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      data_mbe_q   <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            inst_pend_q  <= inst_read;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_addr_q  <= inst_addr;
            data_addr_q  <= data_addr;
            data_wdata_q <= data_wdata;
            data_mbe_q   <= data_mbe;
            // Read+write together is illegal; the write wins.
            if (data_write) begin
              data_op_q <= WR;
            end else if (data_read) begin
              data_op_q <= RD;
            end else begin
              data_op_q <= NONE;
            end
          end
        end
        DATA_ACC: begin
          if (mem_resp) begin
            data_done_q <= 1'b1;
            if (data_op_q == RD) begin
              data_rdata_q <= mem_rdata;
            end
          end
        end
        INST_ACC: begin
          if (mem_resp) begin
            inst_done_q  <= 1'b1;
            inst_rdata_q <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and downstream/CPU strobes; only the access states drive the memory port.
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mbe   = '0;
    inst_resp = 1'b0;
    data_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_read && data_req) begin
          state_d = DATA_FIRST ? DATA_ACC : INST_ACC;
        end else if (data_req) begin
          state_d = DATA_ACC;
        end else if (inst_read) begin
          state_d = INST_ACC;
        end
      end
      DATA_ACC: begin
        mem_addr = word_align(data_addr_q);
        if (data_op_q == WR) begin
          mem_write = 1'b1;
          mem_wdata = data_wdata_q;
          mem_mbe   = data_mbe_q;
        end else begin
          mem_read = 1'b1;
          mem_mbe  = FULL_MBE;
        end
        if (mem_resp) begin
          state_d = (inst_pend_q && !inst_done_q) ? INST_ACC : RESP;
        end
      end
      INST_ACC: begin
        mem_read = 1'b1;
        mem_addr = word_align(inst_addr_q);
        mem_mbe  = FULL_MBE;
        if (mem_resp) begin
          state_d = ((data_op_q != NONE) && !data_done_q) ? DATA_ACC : RESP;
        end
      end
      RESP: begin
        // Joint response: both pulses land in this single cycle.
        inst_resp = inst_pend_q;
        data_resp = (data_op_q != NONE);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifndef SYNTHESIS
  // Simulation-only protocol checks on the CPU request and the downstream strobes.
  always @(posedge clk) begin
    if (!rst) begin
      if (state_q == IDLE && data_read && data_write) begin
        $error("mem_port_responder: data_read and data_write both high; treated as write");
      end
      assert (!(mem_read && mem_write))
        else $error("mem_port_responder: mem_read and mem_write high together");
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_responder.sv
module tb_mem_port_responder;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mbe;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        sel;

  logic [31:0] inst_rdata0, inst_rdata1, data_rdata0, data_rdata1;
  logic        inst_resp0, inst_resp1, data_resp0, data_resp1;
  logic        mem_read0, mem_read1, mem_write0, mem_write1;
  logic [31:0] mem_addr0, mem_addr1, mem_wdata0, mem_wdata1;
  logic [3:0]  mem_mbe0, mem_mbe1;
  logic        mem_resp0, mem_resp1;

  // Muxed view of the DUT currently under test.
  logic [31:0] m_inst_rdata, m_data_rdata, m_addr, m_wdata;
  logic        m_inst_resp, m_data_resp, m_read, m_write;
  logic [3:0]  m_mbe;

  int checks;
  int failures;
  int cyc;

  assign mem_resp0 = mem_resp && !sel;
  assign mem_resp1 = mem_resp && sel;

  assign m_inst_rdata = sel ? inst_rdata1 : inst_rdata0;
  assign m_data_rdata = sel ? data_rdata1 : data_rdata0;
  assign m_inst_resp  = sel ? inst_resp1  : inst_resp0;
  assign m_data_resp  = sel ? data_resp1  : data_resp0;
  assign m_read       = sel ? mem_read1   : mem_read0;
  assign m_write      = sel ? mem_write1  : mem_write0;
  assign m_addr       = sel ? mem_addr1   : mem_addr0;
  assign m_wdata      = sel ? mem_wdata1  : mem_wdata0;
  assign m_mbe        = sel ? mem_mbe1    : mem_mbe0;

  mem_port_responder #(.DATA_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_rdata(inst_rdata0), .inst_resp(inst_resp0),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_mbe(data_mbe), .data_rdata(data_rdata0), .data_resp(data_resp0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_mbe(mem_mbe0), .mem_rdata(mem_rdata), .mem_resp(mem_resp0)
  );

  mem_port_responder #(.DATA_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_rdata(inst_rdata1), .inst_resp(inst_resp1),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_mbe(data_mbe), .data_rdata(data_rdata1), .data_resp(data_resp1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_mbe(mem_mbe1), .mem_rdata(mem_rdata), .mem_resp(mem_resp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_cpu();
    inst_read  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    inst_addr  = 32'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_mbe   = 4'h0;
  endtask

  // Memory model: waits for a strobe, checks it, holds lat cycles, then pulses mem_resp.
  task automatic serve(input string nm, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [3:0] exp_mbe, input logic [31:0] exp_wdata,
                       input logic [31:0] rdata, input int lat);
    int waited;
    waited = 0;
    while (!(m_read || m_write) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!(m_read || m_write)) begin
      failures++;
      $display("FAIL %s_strobe no mem strobe within 20 cycles", nm);
      return;
    end
    checks++;
    if (m_write !== exp_wr || m_read !== !exp_wr) begin
      failures++;
      $display("FAIL %s_dir got rd=%b wr=%b exp wr=%b", nm, m_read, m_write, exp_wr);
    end
    checks++;
    if (m_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s_addr got=%h exp=%h", nm, m_addr, exp_addr);
    end
    checks++;
    if (m_mbe !== exp_mbe) begin
      failures++;
      $display("FAIL %s_mbe got=%b exp=%b", nm, m_mbe, exp_mbe);
    end
    if (exp_wr) begin
      checks++;
      if (m_wdata !== exp_wdata) begin
        failures++;
        $display("FAIL %s_wdata got=%h exp=%h", nm, m_wdata, exp_wdata);
      end
    end
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (m_addr !== exp_addr || !(m_read || m_write)) begin
        failures++;
        $display("FAIL %s_hold got addr=%h strobe=%b exp addr=%h strobe=1", nm, m_addr, m_read | m_write, exp_addr);
      end
    end
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    idle_cpu();
    mem_resp  = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_read, m_write, m_inst_resp, m_data_resp} !== 4'b0 || m_addr !== 32'h0 ||
        m_wdata !== 32'h0 || m_mbe !== 4'h0 || m_inst_rdata !== 32'h0 || m_data_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got rd=%b wr=%b ir=%b dr=%b addr=%h exp all zero",
               m_read, m_write, m_inst_resp, m_data_resp, m_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_inst_only();
    int t0;
    inst_read = 1'b1;
    inst_addr = 32'h60;
    t0 = cyc;
    serve("inst_only", 1'b0, 32'h60, 4'hF, 32'h0, 32'h00A00093, 2);
    // Request sampled in cycle 1, two memory cycles, RESP in cycle 4.
    checks++;
    if (cyc - t0 !== 3) begin
      failures++;
      $display("FAIL inst_only_latency got=%0d exp=3 edges", cyc - t0);
    end
    checks++;
    if (m_inst_resp !== 1'b1 || m_data_resp !== 1'b0) begin
      failures++;
      $display("FAIL inst_only_resp got ir=%b dr=%b exp ir=1 dr=0", m_inst_resp, m_data_resp);
    end
    checks++;
    if (m_inst_rdata !== 32'h00A00093) begin
      failures++;
      $display("FAIL inst_only_rdata got=%h exp=00a00093", m_inst_rdata);
    end
    idle_cpu();
    @(negedge clk);
    checks++;
    if (m_inst_resp !== 1'b0 || m_read !== 1'b0) begin
      failures++;
      $display("FAIL inst_only_pulse got ir=%b rd=%b exp 0 0", m_inst_resp, m_read);
    end
  endtask

  task automatic test_load_fetch();
    int t0;
    inst_read = 1'b1;
    inst_addr = 32'h64;
    data_read = 1'b1;
    data_addr = 32'h1006;
    t0 = cyc;
    serve("lf_data", 1'b0, 32'h1004, 4'hF, 32'h0, 32'hDEADBEEF, 1);
    serve("lf_inst", 1'b0, 32'h64, 4'hF, 32'h0, 32'h00B00113, 1);
    checks++;
    if (cyc - t0 !== 3) begin
      failures++;
      $display("FAIL lf_latency got=%0d exp=3 edges", cyc - t0);
    end
    checks++;
    if (m_inst_resp !== 1'b1 || m_data_resp !== 1'b1) begin
      failures++;
      $display("FAIL lf_joint_resp got ir=%b dr=%b exp 1 1", m_inst_resp, m_data_resp);
    end
    checks++;
    if (m_data_rdata !== 32'hDEADBEEF || m_inst_rdata !== 32'h00B00113) begin
      failures++;
      $display("FAIL lf_rdata got d=%h i=%h exp d=deadbeef i=00b00113", m_data_rdata, m_inst_rdata);
    end
    idle_cpu();
    @(negedge clk);
    checks++;
    if (m_inst_resp !== 1'b0 || m_data_resp !== 1'b0) begin
      failures++;
      $display("FAIL lf_pulse got ir=%b dr=%b exp 0 0", m_inst_resp, m_data_resp);
    end
  endtask

  task automatic test_store();
    inst_read  = 1'b1;
    inst_addr  = 32'h68;
    data_write = 1'b1;
    data_addr  = 32'h2000;
    data_wdata = 32'h0000AB00;
    data_mbe   = 4'b0010;
    serve("st_data", 1'b1, 32'h2000, 4'b0010, 32'h0000AB00, 32'hFFFFFFFF, 1);
    serve("st_inst", 1'b0, 32'h68, 4'hF, 32'h0, 32'h00C00193, 2);
    checks++;
    if (m_inst_resp !== 1'b1 || m_data_resp !== 1'b1) begin
      failures++;
      $display("FAIL st_joint_resp got ir=%b dr=%b exp 1 1", m_inst_resp, m_data_resp);
    end
    checks++;
    if (m_data_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL st_rdata_kept got=%h exp=deadbeef", m_data_rdata);
    end
    idle_cpu();
    @(negedge clk);
  endtask

  task automatic test_data_only();
    // mem_resp in IDLE must not disturb anything.
    mem_resp  = 1'b1;
    mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    mem_resp  = 1'b0;
    checks++;
    if (m_data_rdata !== 32'hDEADBEEF || m_inst_rdata !== 32'h00C00193 || m_read !== 1'b0) begin
      failures++;
      $display("FAIL idle_resp_ignored got d=%h i=%h rd=%b exp deadbeef 00c00193 0",
               m_data_rdata, m_inst_rdata, m_read);
    end
    data_read = 1'b1;
    data_addr = 32'h3008;
    serve("do_data", 1'b0, 32'h3008, 4'hF, 32'h0, 32'h12345678, 1);
    checks++;
    if (m_inst_resp !== 1'b0 || m_data_resp !== 1'b1 || m_data_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL do_resp got ir=%b dr=%b d=%h exp 0 1 12345678", m_inst_resp, m_data_resp, m_data_rdata);
    end
    idle_cpu();
    @(negedge clk);
  endtask

  task automatic test_midflight();
    inst_read = 1'b1;
    inst_addr = 32'h64;
    @(negedge clk);
    inst_addr = 32'h99;
    serve("mf_inst", 1'b0, 32'h64, 4'hF, 32'h0, 32'h00D00213, 3);
    checks++;
    if (m_inst_resp !== 1'b1 || m_inst_rdata !== 32'h00D00213) begin
      failures++;
      $display("FAIL mf_resp got ir=%b i=%h exp 1 00d00213", m_inst_resp, m_inst_rdata);
    end
    idle_cpu();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    inst_read = 1'b1;
    inst_addr = 32'h64;
    data_read = 1'b1;
    data_addr = 32'h1006;
    @(negedge clk);
    checks++;
    if (m_read !== 1'b1 || m_addr !== 32'h1004) begin
      failures++;
      $display("FAIL rm_in_data got rd=%b addr=%h exp 1 00001004", m_read, m_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_read !== 1'b0 || m_write !== 1'b0) begin
      failures++;
      $display("FAIL rm_async_drop got rd=%b wr=%b exp 0 0", m_read, m_write);
    end
    idle_cpu();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (m_inst_resp !== 1'b0 || m_data_resp !== 1'b0) begin
        failures++;
        $display("FAIL rm_no_resp got ir=%b dr=%b exp 0 0", m_inst_resp, m_data_resp);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    inst_read = 1'b1;
    inst_addr = 32'h70;
    serve("rm_after", 1'b0, 32'h70, 4'hF, 32'h0, 32'h00E00293, 1);
    checks++;
    if (m_inst_resp !== 1'b1 || m_data_resp !== 1'b0 || m_inst_rdata !== 32'h00E00293 ||
        m_data_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rm_after_resp got ir=%b dr=%b i=%h d=%h exp 1 0 00e00293 0",
               m_inst_resp, m_data_resp, m_inst_rdata, m_data_rdata);
    end
    idle_cpu();
    @(negedge clk);
  endtask

  task automatic test_order_inst_first();
    sel = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inst_read = 1'b1;
    inst_addr = 32'h64;
    data_read = 1'b1;
    data_addr = 32'h1006;
    serve("ord_inst", 1'b0, 32'h64, 4'hF, 32'h0, 32'h00F00313, 1);
    serve("ord_data", 1'b0, 32'h1004, 4'hF, 32'h0, 32'hCAFEF00D, 1);
    checks++;
    if (m_inst_resp !== 1'b1 || m_data_resp !== 1'b1) begin
      failures++;
      $display("FAIL ord_joint_resp got ir=%b dr=%b exp 1 1", m_inst_resp, m_data_resp);
    end
    checks++;
    if (m_inst_rdata !== 32'h00F00313 || m_data_rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL ord_rdata got i=%h d=%h exp 00f00313 cafef00d", m_inst_rdata, m_data_rdata);
    end
    idle_cpu();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_inst_only();
    test_load_fetch();
    test_store();
    test_data_only();
    test_midflight();
    test_reset_mid();
    test_order_inst_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
